// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES core sequencer.
package aes_seq_pkg;

  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned WIDX_W    = 2;

  typedef logic [WIDX_W-1:0] word_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } seq_state_t;

  localparam logic WSEL_KEY  = 1'b0;
  localparam logic WSEL_DATA = 1'b1;

endpackage

// File: rtl/aes_word_loader.sv
// Assembles a wide register from narrow word writes, MSB word first.
// The counter wraps after the last word, so a further write restarts at word 0
// and drops the full flag until the register has been refilled.
module aes_word_loader
  import aes_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AES_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic [AES_W-1:0]  value,
  output logic              full
);

  word_idx_t idx;

  // Word store, fill counter and full flag; clr only rewinds the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      idx   <= '0;
      full  <= 1'b0;
    end else if (clr) begin
      idx  <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (idx == word_idx_t'(i)) begin
          value[(NUM_WORDS-1-i)*DATA_W +: DATA_W] <= wr_data;
        end
      end
      idx  <= idx + word_idx_t'(1);
      full <= (idx == word_idx_t'(NUM_WORDS-1));
    end
  end

endmodule

// File: rtl/aes_core_sequencer.sv
// Sequences one AES-128 core: loads key/data words, runs the core's
// start/done handshake and streams the result out as four words.
// Optional macro AES_SEQ_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYC cycles.
module aes_core_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned AES_W       = 128,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              wr_valid,
  input  logic              wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              cmd_start,
  input  logic              cmd_mode,
  input  logic              clr_err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [AES_W-1:0]  core_key,
  output logic [AES_W-1:0]  core_din,
  output logic              core_mode,
  output logic              core_start,
  input  logic              core_done,
  input  logic [AES_W-1:0]  core_dout,
  output logic              busy,
  output logic              key_valid,
  output logic              err_start,
  output logic              err_timeout
);

  seq_state_t       state, state_next;
  logic             data_full;
  logic             wr_fire, key_we, data_we, data_clr;
  logic             start_ok, start_bad, done_take, tmo_hit, rd_take;
  word_idx_t        rd_idx;
  logic [AES_W-1:0] result;

  assign wr_fire  = wr_valid & wr_ready;
  assign key_we   = wr_fire & (wr_sel == WSEL_KEY);
  assign data_we  = wr_fire & (wr_sel == WSEL_DATA);
  assign data_clr = done_take | tmo_hit;

  aes_word_loader #(.DATA_W(DATA_W), .AES_W(AES_W)) u_key_loader (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (key_we),
    .wr_data (wr_data),
    .clr     (1'b0),
    .value   (core_key),
    .full    (key_valid)
  );

  aes_word_loader #(.DATA_W(DATA_W), .AES_W(AES_W)) u_data_loader (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (data_we),
    .wr_data (wr_data),
    .clr     (data_clr),
    .value   (core_din),
    .full    (data_full)
  );

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Cycles spent in WAIT; restarts every time WAIT is entered
  always_ff @(posedge ACLK) begin
    if (ARESET || state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag; a new timeout beats a coincident clear
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_hit | (err_timeout & ~clr_err);
    end
  end
`else
  // WAIT is unbounded here; the flag is a constant whatever the limit is set to
  if (TIMEOUT_CYC != 0) begin : g_no_timeout
    assign err_timeout = 1'b0;
  end else begin : g_no_timeout_zero
    assign err_timeout = 1'b0;
  end
`endif

  // Next-state and per-cycle event decode
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    done_take  = 1'b0;
    tmo_hit    = 1'b0;
    rd_take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          if (key_valid && data_full) begin
            start_ok   = 1'b1;
            state_next = START;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (core_done) begin
          done_take  = 1'b1;
          state_next = UNLOAD;
        end
`ifdef AES_SEQ_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC-1)) begin
          tmo_hit    = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      UNLOAD: begin
        if (rd_valid && rd_ready) begin
          rd_take = 1'b1;
          if (rd_idx == word_idx_t'(NUM_WORDS-1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered status/handshake outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      rd_valid   <= 1'b0;
      core_mode  <= 1'b0;
      err_start  <= 1'b0;
      rd_idx     <= '0;
      result     <= '0;
    end else begin
      state      <= state_next;
      wr_ready   <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
      core_start <= (state_next == START);
      rd_valid   <= (state_next == UNLOAD);
      err_start  <= start_bad | (err_start & ~clr_err);
      if (start_ok) begin
        core_mode <= cmd_mode;
      end
      if (done_take) begin
        result <= core_dout;
      end
      if (rd_take) begin
        rd_idx <= rd_idx + word_idx_t'(1);
      end
    end
  end

  // Result word mux, MSB word first
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_idx == word_idx_t'(i)) begin
        rd_data = result[(NUM_WORDS-1-i)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Directed bench for aes_core_sequencer with a hand-driven core model.
module tb_aes_core_sequencer;

  logic         ACLK;
  logic         ARESET;
  logic         wr_valid;
  logic         wr_sel;
  logic [31:0]  wr_data;
  logic         wr_ready;
  logic         cmd_start;
  logic         cmd_mode;
  logic         clr_err;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_ready;
  logic [127:0] core_key;
  logic [127:0] core_din;
  logic         core_mode;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_dout;
  logic         busy;
  logic         key_valid;
  logic         err_start;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] PT  = 128'h3243F6A8_885A308D_313198A2_E0370734;
  localparam logic [127:0] CT  = 128'h3925841D_02DC09FB_DC118597_196A0B32;
  logic [31:0] ct_w [4] = '{32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};
  logic [31:0] key_w [4] = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
  logic [31:0] pt_w [4] = '{32'h3243F6A8, 32'h885A308D, 32'h313198A2, 32'hE0370734};

  aes_core_sequencer #(.DATA_W(32), .AES_W(128), .TIMEOUT_CYC(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .wr_valid    (wr_valid),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .cmd_start   (cmd_start),
    .cmd_mode    (cmd_mode),
    .clr_err     (clr_err),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .core_key    (core_key),
    .core_din    (core_din),
    .core_mode   (core_mode),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_dout   (core_dout),
    .busy        (busy),
    .key_valid   (key_valid),
    .err_start   (err_start),
    .err_timeout (err_timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic write_word(input logic sel, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic mode);
    cmd_start = 1'b1;
    cmd_mode  = mode;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    ARESET = 1'b1;
    tick();
    tick();
    flags = {wr_ready, rd_valid, core_mode, core_start, busy, key_valid, err_start, err_timeout};
    checks++;
    if (flags !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000000", flags);
    end
    checks++;
    if ({core_key, core_din, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data key %h din %h rd %h exp 0", core_key, core_din, rd_data);
    end
    ARESET = 1'b0;
    tick();
    checks++;
    if ({wr_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_ready got %b exp 10", {wr_ready, busy});
    end
  endtask

  task automatic test_encrypt();
    for (int i = 0; i < 3; i++) write_word(1'b0, key_w[i]);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_valid_3w got %b exp 0", key_valid);
    end
    write_word(1'b0, key_w[3]);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL key_valid_4w got %b exp 1", key_valid);
    end
    for (int i = 0; i < 4; i++) write_word(1'b1, pt_w[i]);
    checks++;
    if ({core_key, core_din} !== {KEY, PT}) begin
      errors++;
      $display("FAIL load_regs key %h din %h exp %h %h", core_key, core_din, KEY, PT);
    end
    pulse_start(1'b0);
    checks++;
    if ({core_start, busy, wr_ready, core_mode} !== 4'b1100) begin
      errors++;
      $display("FAIL start_pulse got %b exp 1100", {core_start, busy, wr_ready, core_mode});
    end
    tick();
    checks++;
    if (core_start !== 1'b0) begin
      errors++;
      $display("FAIL start_one_cycle got %b exp 0", core_start);
    end
    tick();
    core_done = 1'b1;
    core_dout = CT;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_early got %b exp 0", rd_valid);
    end
    tick();
    core_done = 1'b0;
    core_dout = '1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, ct_w[i]}) begin
        errors++;
        $display("FAIL enc_word%0d got %b %h exp 1 %h", i, rd_valid, rd_data, ct_w[i]);
      end
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if ({busy, rd_valid, wr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL enc_done got %b exp 001", {busy, rd_valid, wr_ready});
    end
  endtask

  task automatic test_err_start();
    for (int i = 0; i < 3; i++) write_word(1'b1, pt_w[i]);
    pulse_start(1'b1);
    checks++;
    if ({err_start, busy, core_start} !== 3'b100) begin
      errors++;
      $display("FAIL err_start_set got %b exp 100", {err_start, busy, core_start});
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_start !== 1'b0) begin
      errors++;
      $display("FAIL err_start_clr got %b exp 0", err_start);
    end
    clr_err   = 1'b1;
    pulse_start(1'b1);
    clr_err   = 1'b0;
    checks++;
    if (err_start !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins got %b exp 1", err_start);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_same_cycle_and_stall();
    cmd_start = 1'b1;
    cmd_mode  = 1'b1;
    write_word(1'b1, pt_w[3]);
    cmd_start = 1'b0;
    checks++;
    if ({err_start, busy} !== 2'b10) begin
      errors++;
      $display("FAIL same_cycle_start got %b exp 10", {err_start, busy});
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    pulse_start(1'b1);
    checks++;
    if ({busy, core_start, core_mode, core_key, core_din} !== {3'b111, KEY, PT}) begin
      errors++;
      $display("FAIL reuse_start got %b key %h din %h", {busy, core_start, core_mode}, core_key, core_din);
    end
    pulse_start(1'b0);
    core_done = 1'b1;
    core_dout = CT;
    tick();
    core_done = 1'b0;
    checks++;
    if ({err_start, core_mode, rd_valid} !== 3'b011) begin
      errors++;
      $display("FAIL busy_start_ignored got %b exp 011", {err_start, core_mode, rd_valid});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, ct_w[0]}) begin
        errors++;
        $display("FAIL stall_hold%0d got %b %h exp 1 %h", i, rd_valid, rd_data, ct_w[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== ct_w[i]) begin
        errors++;
        $display("FAIL stall_word%0d got %h exp %h", i, rd_data, ct_w[i]);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      tick();
    end
    checks++;
    if ({busy, rd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL stall_done got %b exp 00", {busy, rd_valid});
    end
  endtask

  task automatic test_wrap_and_stray_done();
    for (int i = 0; i < 4; i++) write_word(1'b1, pt_w[i]);
    write_word(1'b1, 32'hDEADBEEF);
    pulse_start(1'b0);
    checks++;
    if ({core_din, err_start, busy} !== {32'hDEADBEEF, PT[95:0], 2'b10}) begin
      errors++;
      $display("FAIL wrap got din %h err %b busy %b", core_din, err_start, busy);
    end
    clr_err   = 1'b1;
    core_done = 1'b1;
    core_dout = CT;
    tick();
    clr_err   = 1'b0;
    core_done = 1'b0;
    tick();
    checks++;
    if ({rd_valid, busy, err_start} !== 3'b000) begin
      errors++;
      $display("FAIL stray_done got %b exp 000", {rd_valid, busy, err_start});
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 4; i++) write_word(1'b1, pt_w[i]);
    pulse_start(1'b0);
    tick();
    checks++;
    if ({busy, core_start} !== 2'b10) begin
      errors++;
      $display("FAIL mid_wait got %b exp 10", {busy, core_start});
    end
    ARESET = 1'b1;
    tick();
    ARESET    = 1'b0;
    core_done = 1'b1;
    core_dout = CT;
    tick();
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd_valid, core_start, busy, key_valid, err_start, err_timeout, core_key, core_din, rd_data}
          !== '0) begin
        errors++;
        $display("FAIL mid_reset%0d got flags %b key %h rd %h exp 0", i,
                 {rd_valid, core_start, busy, key_valid, err_start, err_timeout}, core_key, rd_data);
      end
      tick();
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready got %b exp 1", wr_ready);
    end
  endtask

`ifdef AES_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 4; i++) write_word(1'b0, key_w[i]);
    for (int i = 0; i < 4; i++) write_word(1'b1, pt_w[i]);
    pulse_start(1'b0);
    tick();
    repeat (15) tick();
    checks++;
    if ({busy, err_timeout} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_early got %b exp 10", {busy, err_timeout});
    end
    tick();
    checks++;
    if ({busy, err_timeout, rd_valid} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_hit got %b exp 010", {busy, err_timeout, rd_valid});
    end
    pulse_start(1'b0);
    checks++;
    if ({err_start, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_data_cleared got %b exp 10", {err_start, busy});
    end
  endtask
`endif

  initial begin
    ARESET    = 1'b1;
    wr_valid  = 1'b0;
    wr_sel    = 1'b0;
    wr_data   = '0;
    cmd_start = 1'b0;
    cmd_mode  = 1'b0;
    clr_err   = 1'b0;
    rd_ready  = 1'b0;
    core_done = 1'b0;
    core_dout = '0;
    test_reset();
    test_encrypt();
    test_err_start();
    test_same_cycle_and_stall();
    test_wrap_and_stray_done();
    test_reset_mid();
`ifdef AES_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
